// File: rtl/recover_enc_pkg.sv
// Shared definitions for the Fano re-encoder pipeline.
//   - rib_t          : {hypothesis bit, parity} output word
//   - MASK_*         : default generator masks for the three code rates
//   - calc_stages()  : number of XOR-tree register stages for a given width/fan-in
//   - default_mask() : reset/constant value of each mask slot
package recover_enc_pkg;

  typedef logic [1:0] rib_t;

  localparam logic [88:0] MASK_1_2 = 89'hD354E3267;
  localparam logic [88:0] MASK_3_4 = 89'h87AFC51E7688DDEE;
  localparam logic [88:0] MASK_7_8 = 89'o77663166177600720153763372136;

  // Smallest s with F^s >= k, never below one so the tree always has a register.
  function automatic int calc_stages(input int k, input int log_fanin);
    int n;
    int s;
    n = 1;
    s = 0;
    while (n < k) begin
      n = n << log_fanin;
      s++;
    end
    return (s < 1) ? 1 : s;
  endfunction

  function automatic logic [88:0] default_mask(input int idx);
    case (idx)
      0:       return MASK_1_2;
      1:       return MASK_3_4;
      2:       return MASK_7_8;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/recover_encoder_pipe_xor_tree.sv
// xor_tree_pipe: pipelined parity of a W-bit word.
// Each register stage XORs groups of F = 2^LOG_FANIN bits; the operand is
// zero-extended to F^STAGES bits. All stages advance together on adv.
// Ports:
//   clk, reset_n (sync, active-low), adv (pipeline advance),
//   din [W-1:0] operand, parity (registered result, STAGES cycles later).
module xor_tree_pipe
  import recover_enc_pkg::*;
#(
  parameter int W         = 89,
  parameter int LOG_FANIN = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         adv,
  input  logic [W-1:0] din,
  output logic         parity
);

  localparam int F      = 1 << LOG_FANIN;
  localparam int STAGES = calc_stages(W, LOG_FANIN);
  localparam int PW     = 1 << (LOG_FANIN * STAGES);

  logic [PW-1:0] ext;
  logic [PW-1:0] stg [0:STAGES-1];

  assign ext = PW'(din);

  // Result bits above PW/F stay zero because the upper operand bits are zero.
  function automatic logic [PW-1:0] reduce(input logic [PW-1:0] v);
    logic [PW-1:0] r;
    r = '0;
    for (int j = 0; j < PW / F; j++) r[j] = ^v[j*F +: F];
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int s = 0; s < STAGES; s++) stg[s] <= '0;
    end else if (adv) begin
      stg[0] <= reduce(ext);
      for (int s = 1; s < STAGES; s++) stg[s] <= reduce(stg[s-1]);
    end
  end

  // Only bit 0 of the last stage can be non-zero; reducing the whole word
  // keeps every bit referenced and costs nothing after constant propagation.
  assign parity = ^stg[STAGES-1];

endmodule

// File: rtl/recover_encoder_pipe.sv
// recover_encoder_pipe: re-encoder for the Fano decoder tree search.
// For every accepted path-register word it produces the parity of
// (register & generator mask) for bit0 hypotheses 0 and 1, optionally
// differentially combined with i_data[0]. Latency 1 + STAGES cycles.
// Optional feature: define RECOVER_ENC_MASK_WR_EN for a writable mask table
// (i_mask_wr/i_mask_idx/i_mask_data); otherwise masks are constants and the
// write ports are ignored.
// Ports:
//   clk, reset_n (sync, active-low)
//   i_vld/o_rdy, i_data [K-1:0], i_diff_en, i_code_rate [RW-1:0] : input beat
//   o_vld/i_rdy, o_rib_0, o_rib_1                                : output beat
//   i_mask_wr, i_mask_idx [RW-1:0], i_mask_data [K-1:0]          : mask write
module recover_encoder_pipe
  import recover_enc_pkg::*;
#(
  parameter int K         = 89,
  parameter int LOG_FANIN = 1,
  parameter int N_RATES   = 3,
  parameter int DEBUG     = 0,
  localparam int RW       = (N_RATES > 1) ? $clog2(N_RATES) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_diff_en,
  input  logic [RW-1:0] i_code_rate,
  input  logic          i_vld,
  output logic          o_rdy,
  input  logic [K-1:0]  i_data,
  output logic          o_vld,
  input  logic          i_rdy,
  output rib_t          o_rib_0,
  output rib_t          o_rib_1,
  input  logic          i_mask_wr,
  input  logic [RW-1:0] i_mask_idx,
  input  logic [K-1:0]  i_mask_data
);

  localparam int STAGES       = calc_stages(K, LOG_FANIN);
  localparam logic [RW:0] NR  = (RW + 1)'(N_RATES);

  logic              adv;
  logic [STAGES:0]   vld;
  logic [RW-1:0]     rate_eff;
  logic [K-1:0]      mask_cur;
  logic              b0_0;
  logic              b0_1;
  logic [K-1:0]      s0_0;
  logic [K-1:0]      s0_1;
  logic              parity_0;
  logic              parity_1;

  assign o_vld = vld[STAGES];
  assign adv   = !o_vld || i_rdy;
  assign o_rdy = adv || !reset_n;

  // Out-of-range rates fall back to slot 0.
  assign rate_eff = ({1'b0, i_code_rate} < NR) ? i_code_rate : '0;

`ifdef RECOVER_ENC_MASK_WR_EN
  logic [K-1:0] mask_tbl [N_RATES];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < N_RATES; i++) mask_tbl[i] <= K'(default_mask(i));
    end else if (i_mask_wr && ({1'b0, i_mask_idx} < NR)) begin
      mask_tbl[i_mask_idx] <= i_mask_data;
    end
  end

  // Read before the edge, so a beat accepted alongside a write sees the old mask.
  assign mask_cur = mask_tbl[rate_eff];
`else
  logic unused_mask_ports;
  assign unused_mask_ports = ^{i_mask_wr, i_mask_idx, i_mask_data};
  assign mask_cur = K'(default_mask(int'(rate_eff)));
`endif

  assign b0_0 = i_diff_en & i_data[0];
  assign b0_1 = ~b0_0;

  // Stage 0 loads on every advance; contents of empty slots are don't-care
  // since the valid chain marks them.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld  <= '0;
      s0_0 <= '0;
      s0_1 <= '0;
    end else if (adv) begin
      vld  <= {vld[STAGES-1:0], i_vld};
      s0_0 <= {i_data[K-1:1], b0_0} & mask_cur;
      s0_1 <= {i_data[K-1:1], b0_1} & mask_cur;
    end
  end

  xor_tree_pipe #(.W(K), .LOG_FANIN(LOG_FANIN)) u_tree_0 (
    .clk     (clk),
    .reset_n (reset_n),
    .adv     (adv),
    .din     (s0_0),
    .parity  (parity_0)
  );

  xor_tree_pipe #(.W(K), .LOG_FANIN(LOG_FANIN)) u_tree_1 (
    .clk     (clk),
    .reset_n (reset_n),
    .adv     (adv),
    .din     (s0_1),
    .parity  (parity_1)
  );

  assign o_rib_0 = {1'b0, parity_0};
  assign o_rib_1 = {1'b1, parity_1};

  // Probe bundle kept through synthesis for an ILA to attach to.
  if (DEBUG != 0) begin : g_debug
    (* mark_debug = "true" *) logic [7:0] dbg_probe;
    assign dbg_probe = {i_vld, o_rdy, o_vld, i_rdy, o_rib_0, o_rib_1};
  end

endmodule

// File: tb/tb_recover_encoder_pipe.sv
module tb_recover_encoder_pipe;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_diff_en;
  logic [1:0]  i_code_rate;
  logic        i_vld;
  logic        o_rdy;
  logic [88:0] i_data;
  logic        o_vld;
  logic        i_rdy;
  logic [1:0]  o_rib_0;
  logic [1:0]  o_rib_1;
  logic        i_mask_wr;
  logic [1:0]  i_mask_idx;
  logic [88:0] i_mask_data;

  always #5 clk = ~clk;

  recover_encoder_pipe dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_diff_en   (i_diff_en),
    .i_code_rate (i_code_rate),
    .i_vld       (i_vld),
    .o_rdy       (o_rdy),
    .i_data      (i_data),
    .o_vld       (o_vld),
    .i_rdy       (i_rdy),
    .o_rib_0     (o_rib_0),
    .o_rib_1     (o_rib_1),
    .i_mask_wr   (i_mask_wr),
    .i_mask_idx  (i_mask_idx),
    .i_mask_data (i_mask_data)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [1:0] r0;
    logic [1:0] r1;
    int         c;
  } exp_t;

  exp_t sb[$];
  logic [88:0] mdl_mask [3];

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic model_defaults();
    mdl_mask[0] = 89'hD354E3267;
    mdl_mask[1] = 89'h87AFC51E7688DDEE;
    mdl_mask[2] = 89'o77663166177600720153763372136;
  endtask

  function automatic logic [88:0] rnd89();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[88:0];
  endfunction

  function automatic logic [1:0] exp_rib(input logic [88:0] d, input logic h,
                                         input logic diff, input logic [1:0] rate);
    logic [88:0] m;
    logic [88:0] v;
    logic        b0;
    m  = (rate < 2'd3) ? mdl_mask[rate] : mdl_mask[0];
    b0 = h ^ (diff & d[0]);
    v  = {d[88:1], b0} & m;
    return {h, ^v};
  endfunction

  task automatic test_reset();
    logic seen;
    reset_n = 1'b0; i_vld = 1'b1; i_data = rnd89(); i_rdy = 1'b1;
    i_code_rate = 2'd0; i_diff_en = 1'b0;
    i_mask_wr = 1'b0; i_mask_idx = 2'd0; i_mask_data = '0;
    step(); step(); #1;
    total++; if (o_vld !== 1'b0) begin bad++; $display("FAIL reset_vld got=%b exp=0", o_vld); end
    total++; if (o_rib_0 !== 2'b00 || o_rib_1 !== 2'b10) begin bad++;
      $display("FAIL reset_rib got=%b/%b exp=00/10", o_rib_0, o_rib_1); end
    total++; if (o_rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy got=%b exp=1", o_rdy); end
    reset_n = 1'b1; i_vld = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 12; n++) begin step(); #1; if (o_vld !== 1'b0) seen = 1'b1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL reset_discard got=%b exp=0", seen); end
    model_defaults();
    sb.delete();
  endtask

  task automatic test_latency();
    int lat;
    logic [1:0] r0, r1;
    lat = -1; r0 = 'x; r1 = 'x;
    i_vld = 1'b1; i_data = '0; i_code_rate = 2'd0; i_diff_en = 1'b0; i_rdy = 1'b1;
    step();
    i_vld = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      #1;
      if (o_vld === 1'b1) begin lat = n; r0 = o_rib_0; r1 = o_rib_1; break; end
      step();
    end
    total++; if (lat !== 8) begin bad++; $display("FAIL latency got=%0d exp=8", lat); end
    total++; if (r0 !== 2'b00 || r1 !== 2'b11) begin bad++;
      $display("FAIL rate0_zero got=%b/%b exp=00/11", r0, r1); end
    step();
  endtask

  task automatic test_mask_write();
    logic [1:0] r0 [2];
    logic [1:0] r1 [2];
    logic [1:0] exp_b0;
    int got;
    got = 0;
    r0[0] = 'x; r0[1] = 'x; r1[0] = 'x; r1[1] = 'x;
    i_rdy = 1'b1;
    i_mask_wr = 1'b1; i_mask_idx = 2'd1; i_mask_data = 89'h1;
    i_vld = 1'b1; i_code_rate = 2'd1; i_data = 89'h1; i_diff_en = 1'b1;
    step();
    i_mask_wr = 1'b0;
    step();
    i_vld = 1'b0; i_diff_en = 1'b0;
`ifdef RECOVER_ENC_MASK_WR_EN
    mdl_mask[1] = 89'h1;
    exp_b0 = 2'b01;
`else
    exp_b0 = 2'b00;
`endif
    for (int n = 0; n < 20; n++) begin
      #1;
      if (o_vld === 1'b1) begin r0[got] = o_rib_0; r1[got] = o_rib_1; got++; end
      step();
      if (got == 2) break;
    end
    total++; if (got !== 2) begin bad++; $display("FAIL mw_count got=%0d exp=2", got); end
    total++; if (r0[0] !== 2'b00 || r1[0] !== 2'b10) begin bad++;
      $display("FAIL mw_same_cycle got=%b/%b exp=00/10", r0[0], r1[0]); end
    total++; if (r0[1] !== exp_b0 || r1[1] !== 2'b10) begin bad++;
      $display("FAIL mw_next_beat got=%b/%b exp=%b/10", r0[1], r1[1], exp_b0); end
  endtask

  task automatic test_back_to_back();
    int sent, outs;
    exp_t e;
    sent = 0; outs = 0;
    sb.delete();
    i_rdy = 1'b1;
    for (int n = 0; n < 200 && outs < 100; n++) begin
      if (sent < 100) begin
        i_vld = 1'b1; i_data = rnd89();
        i_code_rate = 2'($urandom_range(0, 2)); i_diff_en = 1'($urandom_range(0, 1));
      end else begin
        i_vld = 1'b0;
      end
      #1;
      if (o_vld === 1'b1) begin
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL b2b_extra got=out exp=none"); end
        else begin
          e = sb.pop_front();
          if (o_rib_0 !== e.r0 || o_rib_1 !== e.r1 || cyc !== e.c + 8) begin bad++;
            $display("FAIL b2b_beat got=%b/%b@%0d exp=%b/%b@%0d", o_rib_0, o_rib_1, cyc, e.r0, e.r1, e.c + 8);
          end
        end
        outs++;
      end
      if (i_vld === 1'b1 && o_rdy === 1'b1) begin
        e.r0 = exp_rib(i_data, 1'b0, i_diff_en, i_code_rate);
        e.r1 = exp_rib(i_data, 1'b1, i_diff_en, i_code_rate);
        e.c  = cyc;
        sb.push_back(e);
        sent++;
      end
      step();
    end
    i_vld = 1'b0;
    total++; if (outs !== 100 || sb.size() !== 0) begin bad++;
      $display("FAIL b2b_total got=%0d/%0d exp=100/0", outs, sb.size()); end
  endtask

  task automatic test_backpressure();
    int sent, outs;
    logic prev_stall;
    logic [1:0] p0, p1;
    exp_t e;
    sent = 0; outs = 0; prev_stall = 1'b0; p0 = '0; p1 = '0;
    sb.delete();
    for (int n = 0; n < 10000 && outs < 500; n++) begin
      i_vld = (sent < 500) && ($urandom_range(0, 99) < 70);
      i_data = rnd89();
      i_code_rate = 2'($urandom_range(0, 2)); i_diff_en = 1'($urandom_range(0, 1));
      i_rdy = ($urandom_range(0, 99) < 30);
      #1;
      total++;
      if (o_rdy !== (!o_vld || i_rdy)) begin bad++;
        $display("FAIL bp_rdy got=%b exp=%b", o_rdy, (!o_vld || i_rdy)); end
      if (prev_stall) begin
        total++;
        if (o_vld !== 1'b1 || o_rib_0 !== p0 || o_rib_1 !== p1) begin bad++;
          $display("FAIL bp_hold got=%b %b/%b exp=1 %b/%b", o_vld, o_rib_0, o_rib_1, p0, p1); end
      end
      if (o_vld === 1'b1 && i_rdy === 1'b1) begin
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL bp_extra got=out exp=none"); end
        else begin
          e = sb.pop_front();
          if (o_rib_0 !== e.r0 || o_rib_1 !== e.r1) begin bad++;
            $display("FAIL bp_beat got=%b/%b exp=%b/%b", o_rib_0, o_rib_1, e.r0, e.r1); end
        end
        outs++;
      end
      if (i_vld === 1'b1 && o_rdy === 1'b1) begin
        e.r0 = exp_rib(i_data, 1'b0, i_diff_en, i_code_rate);
        e.r1 = exp_rib(i_data, 1'b1, i_diff_en, i_code_rate);
        e.c  = cyc;
        sb.push_back(e);
        sent++;
      end
      prev_stall = o_vld && !i_rdy;
      p0 = o_rib_0; p1 = o_rib_1;
      step();
    end
    i_vld = 1'b0; i_rdy = 1'b1;
    total++; if (outs !== 500 || sb.size() !== 0) begin bad++;
      $display("FAIL bp_total got=%0d/%0d exp=500/0", outs, sb.size()); end
  endtask

  task automatic test_reset_midstream();
    logic seen;
    logic [1:0] r0, r1;
    r0 = 'x; r1 = 'x;
    i_rdy = 1'b1; i_vld = 1'b0;
    i_mask_wr = 1'b1; i_mask_idx = 2'd2; i_mask_data = '1;
    step();
    i_mask_wr = 1'b0;
`ifdef RECOVER_ENC_MASK_WR_EN
    mdl_mask[2] = '1;
`endif
    for (int n = 0; n < 5; n++) begin
      i_vld = 1'b1; i_data = rnd89(); i_code_rate = 2'($urandom_range(0, 2));
      step();
    end
    reset_n = 1'b0; i_vld = 1'b1; i_data = rnd89();
    #1;
    total++; if (o_rdy !== 1'b1) begin bad++; $display("FAIL mid_rst_rdy got=%b exp=1", o_rdy); end
    step();
    reset_n = 1'b1; i_vld = 1'b0;
    #1;
    total++; if (o_vld !== 1'b0 || o_rib_0 !== 2'b00 || o_rib_1 !== 2'b10) begin bad++;
      $display("FAIL mid_rst_out got=%b %b/%b exp=0 00/10", o_vld, o_rib_0, o_rib_1); end
    seen = 1'b0;
    for (int n = 0; n < 12; n++) begin step(); #1; if (o_vld !== 1'b0) seen = 1'b1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL mid_stale got=%b exp=0", seen); end
    model_defaults();
    sb.delete();
    i_vld = 1'b1; i_data = '0; i_diff_en = 1'b0; i_code_rate = 2'd2;
    step();
    i_vld = 1'b0;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (o_vld === 1'b1) begin r0 = o_rib_0; r1 = o_rib_1; break; end
      step();
    end
    total++; if (r0 !== 2'b00 || r1 !== 2'b10) begin bad++;
      $display("FAIL mid_mask_revert got=%b/%b exp=00/10", r0, r1); end
    step();
  endtask

  task automatic test_rate_oob();
    logic [1:0] rates [9];
    int sent, outs;
    exp_t e;
    rates = '{2'd3, 2'd3, 2'd3, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    sent = 0; outs = 0;
    sb.delete();
    i_rdy = 1'b1;
    for (int n = 0; n < 40 && outs < 9; n++) begin
      i_mask_wr = (sent == 3); i_mask_idx = 2'd3; i_mask_data = '1;
      if (sent < 9) begin
        i_vld = 1'b1; i_code_rate = rates[sent];
        i_data = (sent == 0) ? '0 : rnd89();
        i_diff_en = (sent == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      end else begin
        i_vld = 1'b0;
      end
      #1;
      if (o_vld === 1'b1) begin
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL oob_extra got=out exp=none"); end
        else begin
          e = sb.pop_front();
          if (o_rib_0 !== e.r0 || o_rib_1 !== e.r1) begin bad++;
            $display("FAIL oob_beat%0d got=%b/%b exp=%b/%b", outs, o_rib_0, o_rib_1, e.r0, e.r1); end
        end
        outs++;
      end
      if (i_vld === 1'b1 && o_rdy === 1'b1) begin
        e.r0 = exp_rib(i_data, 1'b0, i_diff_en, i_code_rate);
        e.r1 = exp_rib(i_data, 1'b1, i_diff_en, i_code_rate);
        e.c  = cyc;
        sb.push_back(e);
        sent++;
      end
      step();
    end
    i_vld = 1'b0; i_mask_wr = 1'b0;
    total++; if (outs !== 9) begin bad++; $display("FAIL oob_total got=%0d exp=9", outs); end
  endtask

  initial begin
    model_defaults();
    test_reset();
    test_latency();
    test_mask_write();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    test_rate_oob();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/recover_encoder_pipe.md
Name: recover_encoder_pipe

Overview:
Parametrised re-encoder for the Fano decoder's tree search.
- For every incoming path-register word, computes the parity of (register AND generator mask) for each branch hypothesis (bit0 forced to 0 and to 1, optionally differentially combined with data bit 0).
- Generalises the fixed 89-bit / 2-branch re-encoder:
  - parametric register length and XOR-tree fan-in per pipeline stage;
  - per-beat code-rate selection, with no reset needed to switch;
  - valid/ready backpressure through the whole pipeline.
- Sits between the decoder's path-register/backtrack logic and the branch-metric unit.

Parameters:
- K, 89: path-register width (bits of i_data).
- LOG_FANIN, 1: log2 of XOR inputs per tree stage (1 gives a binary tree).
- N_RATES, 3: number of selectable masks (code rates); selector width RW = max(1, clog2(N_RATES)).
- DEBUG, 0: instantiate an ILA on the port signals when 1.

Ports:
- clk, in, 1: clock.
- reset_n, in, 1: reset, synchronous, active-low.
- i_diff_en, in, 1: differential combine of bit0 with i_data[0]; sampled per accepted beat.
- i_code_rate, in, RW: mask index (0 = 1/2, 1 = 3/4, 2 = 7/8); sampled per accepted beat.
- i_vld, in, 1: input beat valid.
- o_rdy, out, 1: input ready.
- i_data, in, K: path-register word.
- o_vld, out, 1: output valid.
- i_rdy, in, 1: downstream ready.
- o_rib_0, out, 2: {1'b0, parity for hypothesis 0}.
- o_rib_1, out, 2: {1'b1, parity for hypothesis 1}.
- i_mask_wr, in, 1: mask write strobe (feature-dependent).
- i_mask_idx, in, RW: mask slot to write.
- i_mask_data, in, K: mask value to write.

Behaviour:
- Derived constants:
  - F = 2^LOG_FANIN.
  - STAGES = ceil(log_F(K)); K=89 with LOG_FANIN=1 gives 7.
  - Latency L = 1 + STAGES cycles from accepted input to o_vld; 8 for the defaults.
- Stage 0 (one register per hypothesis h in {0,1}):
  - b0_h = h XOR (i_diff_en ? i_data[0] : 0).
  - s0_h = {i_data[K-1:1], b0_h} & mask[i_code_rate].
  - Mask, diff and hypothesis are bound to the beat. Rate changes take effect on the next accepted beat, with no flush and no reset.
  - i_code_rate >= N_RATES selects mask 0.
- Tree stages:
  - Each stage XORs groups of F bits. The operand is zero-extended to F^STAGES bits.
  - Both hypotheses are computed in parallel; the final stage yields parity_h.
- Pipeline control:
  - Per-stage valid bits form a shift chain.
  - Global advance: adv = !o_vld | i_rdy.
  - o_rdy = adv; an input beat is accepted when i_vld & o_rdy.
  - When adv = 0, all data and valid registers hold. No beat is lost or duplicated under arbitrary i_rdy patterns.
  - Bubbles are not compressed; there is no skid buffer.
  - Throughput is 1 beat/cycle while i_rdy = 1.
- Outputs:
  - o_rib_0 = {0, parity_0}; o_rib_1 = {1, parity_1}.
  - Both are stable while o_vld & !i_rdy.
- Reset (reset_n = 0 on a clock edge):
  - All valid bits, data stages and parities clear; o_vld = 0, o_rib_0 = 2'b00, o_rib_1 = 2'b10.
  - o_rdy = 1 during reset, but beats presented during reset are discarded.
  - Reset mid-stream drops all in-flight beats.
  - The mask table reloads its defaults: slot 0 = 89'hD354E3267, slot 1 = 89'h87AFC51E7688DDEE, slot 2 = 89'o77663166177600720153763372136; further slots = 0.
- Mask write (feature enabled):
  - On i_mask_wr = 1 with reset_n = 1, slot i_mask_idx takes i_mask_data at the clock edge.
  - An input beat accepted in the same cycle uses the old value; the next beat uses the new one.
  - A write to an index >= N_RATES is ignored.

Optional Feature:
- Macro RECOVER_ENC_MASK_WR_EN.
- Defined: the mask table is a register array, reset to the defaults and writable via i_mask_wr / i_mask_idx / i_mask_data as above.
- Undefined: masks are package constants; the write ports exist but are ignored, and no mask flops are synthesised.

Decomposition:
- Package recover_enc_pkg holds:
  - default mask constants;
  - a localparam function computing STAGES from K and LOG_FANIN;
  - a rib_t typedef (logic [1:0]).
- Natural sub-module: xor_tree_pipe (params W, LOG_FANIN), with an advance input and a W-bit in / 1-bit parity out.
  - Instantiated once per hypothesis.
  - The top level holds the valid chain, handshake, diff logic and mask table.

Test Plan:
1. Defaults, mask 0, i_data = 0, diff off, i_rdy = 1 -> after 8 cycles o_vld = 1, o_rib_0 = 2'b00, o_rib_1 = 2'b11 (mask bit0 = 1).
2. Mask write slot 1 = 89'h1, rate 1, i_data = 89'h1, diff on -> o_rib_0 = 2'b01, o_rib_1 = 2'b10. With the macro undefined -> same stimulus gives parities per default mask_3_4 (bit0 = 0): o_rib_0 = 2'b00, o_rib_1 = 2'b10.
3. 100 back-to-back beats of random data and random rate per beat, i_rdy = 1 -> 100 outputs in order, each matching a reference popcount parity, with exactly one cycle per beat after latency 8.
4. Random i_rdy at 30% duty -> o_rdy = !o_vld | i_rdy each cycle; outputs held stable while stalled; no loss or duplication across 500 beats.
5. reset_n pulled low for 1 cycle with 5 beats in flight -> o_vld = 0 next cycle; no stale outputs appear; a written mask reverts to the default.
6. i_code_rate = 3 with N_RATES = 3 -> behaves exactly as rate 0; a mask write to idx 3 leaves all slots unchanged.
